alu_ctrl_table: RTL and testbench
=================================

Name: alu_ctrl_table

Overview:
Writable, parametrised successor to the fixed ALU-control lookup. Maps a decoded index ({funct7[5], funct3} in the default layout) to an ALU control code. The table self-loads the RV32I default mapping after reset or on request, and firmware/debug can then overwrite it. Read has registered 1-cycle latency with valid and illegal flags, plus a saturating illegal-lookup counter. Sits between instruction decode and the ALU in the non-pipelined core.

Parameters:
ADDR_W, 4, index width; DEPTH = 2**ADDR_W entries
CTRL_W, 4, ALU control code width (must be >= 4)
ILL_CNT_W, 8, width of illegal-lookup counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
rd_en  in  1  lookup request
rd_addr  in  ADDR_W  lookup index
wr_en  in  1  table write request
wr_addr  in  ADDR_W  write index
wr_data  in  CTRL_W  write value
restore  in  1  pulse: reload default table
busy  out  1  high while default load in progress
rd_valid  out  1  ctrl_out/illegal valid this cycle
ctrl_out  out  CTRL_W  looked-up control code
illegal  out  1  looked-up code == ILLEGAL (all ones)
ill_count  out  ILL_CNT_W  saturating count of illegal lookups

Behaviour:
- ILLEGAL = {CTRL_W{1'b1}}.
- Default contents:
  - 0->0 ADD, 8->1 SUB, 1->4 SLL, 2->5 SLT, 3->6 SLTU, 4->7 XOR, 5->8 SRL, 13->9 SRA, 6->3 OR, 7->2 AND.
  - All other indices, including every index >= 16 when ADDR_W > 4, are ILLEGAL.
- FSM states: INIT, READY.
- Reset (rst_n=0 at an edge):
  - state=INIT, init_cnt=0.
  - busy=1, rd_valid=0, ctrl_out=ILLEGAL, illegal=0, ill_count=0.
  - Table contents are undefined until INIT completes.
- INIT:
  - Each cycle writes default[init_cnt] and increments init_cnt.
  - After writing entry DEPTH-1, next state is READY and busy drops to 0. busy is high for exactly DEPTH cycles after reset release.
  - rd_en, wr_en and restore are ignored.
  - rd_valid=0.
  - Reset asserted mid-INIT restarts at init_cnt=0.
- READY read:
  - rd_en=1 at edge N gives, after edge N+1: rd_valid=1, ctrl_out=table[rd_addr], illegal=(ctrl_out==ILLEGAL).
  - rd_valid is a single-cycle pulse per request.
  - Back-to-back reads give one result per cycle.
  - When rd_valid=0, ctrl_out and illegal hold their last values.
- READY write:
  - wr_en=1 updates table[wr_addr]=wr_data at that edge.
  - Writing ILLEGAL is legal and marks the entry illegal.
- Same-cycle rd_en and wr_en to the same address: write-first. The read result is wr_data.
  - Different addresses: both complete independently.
- ill_count:
  - Increments by 1 in the cycle rd_valid&illegal is presented (registered alongside).
  - Saturates at 2**ILL_CNT_W-1.
  - Cleared only by reset. restore does not clear it.
- restore=1 in READY:
  - Next state INIT, init_cnt=0, busy=1 on the following cycle.
  - A same-cycle wr_en is dropped.
  - A same-cycle rd_en is still served (rd_valid next cycle) from pre-restore contents.
  - Restore also reverts all user writes.
- No X on any output after reset. rd_addr/wr_addr are always in range because DEPTH = 2**ADDR_W.

Test Plan:
- Reset then idle → busy=1 for exactly 16 cycles after rst_n rises, then 0. rd_valid=0, ctrl_out=4'hF, ill_count=0 throughout.
- After init, read indices 0,8,1,2,3,4,5,13,6,7 back-to-back → ctrl_out 0,1,4,5,6,7,8,9,3,2 one cycle after each request. illegal=0 and rd_valid=1 each cycle.
- Read index 9 then 15 → ctrl_out=4'hF with illegal=1 twice, ill_count 0→1→2. Repeat 300 illegal reads with ILL_CNT_W=8 → ill_count holds 255.
- Write 8→4'hA with a same-cycle read of 8 → that read returns 4'hA (write-first). Next read of 8 → 4'hA. Write 1→4'hF then read 1 → illegal=1.
- After the writes above, pulse restore → busy=1 for 16 cycles. Reads and writes during busy are ignored (rd_valid stays 0). Afterwards read 8 → 1, read 1 → 4, ill_count unchanged.
- Assert rst_n=0 at init_cnt=7, release → busy=1 for a full 16 cycles. All defaults correct. ill_count=0.

Source files
------------

// File: rtl/alu_ctrl_table.sv
// Writable ALU-control lookup table: self-loads the RV32I default mapping after reset
// or on restore, then serves registered 1-cycle reads with an illegal flag and counter.
module alu_ctrl_table #(
    parameter int ADDR_W    = 4,
    parameter int CTRL_W    = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [CTRL_W-1:0]    wr_data,
    input  logic                 restore,
    output logic                 busy,
    output logic                 rd_valid,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CTRL_W-1:0] ILLEGAL = '1;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      initCnt_q, initCnt_d;
    logic [CTRL_W-1:0]      ctrlTable_q [DEPTH];

    logic                   rdValid_q, rdValid_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic                   illegal_q, illegal_d;
    logic [ILL_CNT_W-1:0]   illCnt_q, illCnt_d;

    logic                   initWrite;
    logic                   rdAccept;
    logic                   wrAccept;
    logic [CTRL_W-1:0]      lookup;
    logic                   lookupIllegal;

    // RV32I default mapping indexed by {funct7[5], funct3}; anything else is ILLEGAL
    function automatic logic [CTRL_W-1:0] defaultCode(input logic [ADDR_W-1:0] idx);
        logic [CTRL_W-1:0] code;
        code = ILLEGAL;
        case (int'(idx))
            0:       code = CTRL_W'(4'd0);
            8:       code = CTRL_W'(4'd1);
            1:       code = CTRL_W'(4'd4);
            2:       code = CTRL_W'(4'd5);
            3:       code = CTRL_W'(4'd6);
            4:       code = CTRL_W'(4'd7);
            5:       code = CTRL_W'(4'd8);
            13:      code = CTRL_W'(4'd9);
            6:       code = CTRL_W'(4'd3);
            7:       code = CTRL_W'(4'd2);
            default: code = ILLEGAL;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        case (state_q)
            INIT: begin
                initCnt_d = initCnt_q + 1'b1;
                if (initCnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (restore) begin
                    state_d   = INIT;
                    initCnt_d = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // A write arriving with restore is dropped, since the reload would discard it anyway
    always_comb begin
        busy      = 1'b0;
        initWrite = 1'b0;
        rdAccept  = 1'b0;
        wrAccept  = 1'b0;
        case (state_q)
            INIT: begin
                busy      = 1'b1;
                initWrite = 1'b1;
            end
            READY: begin
                rdAccept = rd_en;
                wrAccept = wr_en & ~restore;
            end
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (initWrite) begin
                ctrlTable_q[initCnt_q] <= defaultCode(initCnt_q);
            end else if (wrAccept) begin
                ctrlTable_q[wr_addr] <= wr_data;
            end
        end
    end

    // Write-first bypass so a same-address read sees the value being written
    always_comb begin
        lookup        = ctrlTable_q[rd_addr];
        if (wrAccept && (wr_addr == rd_addr)) begin
            lookup = wr_data;
        end
        lookupIllegal = (lookup == ILLEGAL);
    end

    always_comb begin
        rdValid_d = rdAccept;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        illCnt_d  = illCnt_q;
        if (rdAccept) begin
            ctrl_d    = lookup;
            illegal_d = lookupIllegal;
            if (lookupIllegal && (illCnt_q != '1)) begin
                illCnt_d = illCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdValid_q <= 1'b0;
            ctrl_q    <= ILLEGAL;
            illegal_q <= 1'b0;
            illCnt_q  <= '0;
        end else begin
            rdValid_q <= rdValid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            illCnt_q  <= illCnt_d;
        end
    end

    assign rd_valid  = rdValid_q;
    assign ctrl_out  = ctrl_q;
    assign illegal   = illegal_q;
    assign ill_count = illCnt_q;

endmodule

// File: tb/tb_alu_ctrl_table.sv
// Bench for alu_ctrl_table: a table-level reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_alu_ctrl_table;

    localparam int ADDR_W    = 4;
    localparam int CTRL_W    = 4;
    localparam int ILL_CNT_W = 8;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [CTRL_W-1:0]    wr_data;
    logic                 restore;
    logic                 busy;
    logic                 rd_valid;
    logic [CTRL_W-1:0]    ctrl_out;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_table #(
        .ADDR_W   (ADDR_W),
        .CTRL_W   (CTRL_W),
        .ILL_CNT_W(ILL_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .restore  (restore),
        .busy     (busy),
        .rd_valid (rd_valid),
        .ctrl_out (ctrl_out),
        .illegal  (illegal),
        .ill_count(ill_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] defaultOf(input int idx);
        case (idx)
            0: return 4'd0;   8: return 4'd1;   1: return 4'd4;   2: return 4'd5;
            3: return 4'd6;   4: return 4'd7;   5: return 4'd8;  13: return 4'd9;
            6: return 4'd3;   7: return 4'd2;
            default: return 4'hF;
        endcase
    endfunction

    // Reference model: a reload simply replaces the whole table, and busy is a
    // countdown of the cycles during which requests are ignored.
    logic [3:0] modelTbl [DEPTH];
    int         busyLeft = 0;
    bit         armed    = 1'b0;
    logic       expValid;
    logic [3:0] expCtrl;
    logic       expIll;
    int         expCnt;

    always @(posedge clk) begin
        logic [3:0] v;
        if (!rst_n) begin
            armed    = 1'b1;
            busyLeft = DEPTH;
            expValid = 1'b0;
            expCtrl  = 4'hF;
            expIll   = 1'b0;
            expCnt   = 0;
            for (int i = 0; i < DEPTH; i++) modelTbl[i] = defaultOf(i);
        end else if (armed) begin
            if (busyLeft > 0) begin
                busyLeft--;
                expValid = 1'b0;
            end else begin
                expValid = rd_en;
                if (rd_en) begin
                    if (wr_en && !restore && wr_addr == rd_addr) v = wr_data;
                    else v = modelTbl[rd_addr];
                    expCtrl = v;
                    expIll  = (v == 4'hF);
                    if (expIll && expCnt < 255) expCnt++;
                end
                if (wr_en && !restore) modelTbl[wr_addr] = wr_data;
                if (restore) begin
                    busyLeft = DEPTH;
                    for (int i = 0; i < DEPTH; i++) modelTbl[i] = defaultOf(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("m_busy", 32'(busy), 32'(busyLeft > 0));
            checkOutput("m_rd_valid", 32'(rd_valid), 32'(expValid));
            checkOutput("m_ctrl_out", 32'(ctrl_out), 32'(expCtrl));
            checkOutput("m_illegal", 32'(illegal), 32'(expIll));
            checkOutput("m_ill_count", 32'(ill_count), 32'(expCnt));
        end
    end

    // One clock of stimulus; outputs for the request are visible on return
    task automatic applyStimulus(input logic re, input int ra, input logic we, input int wa,
                                 input logic [3:0] wd, input logic rs);
        rd_en   = re;
        rd_addr = ADDR_W'(ra);
        wr_en   = we;
        wr_addr = ADDR_W'(wa);
        wr_data = wd;
        restore = rs;
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        restore = 1'b0;
    endtask

    // Counts cycles with busy high, optionally poking reads/writes that must be ignored
    task automatic measureBusy(input bit poke, output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (poke) begin
                applyStimulus(1'b1, 8, 1'b1, 8, 4'h5, 1'b0);
                checkOutput("rd_valid_during_busy", 32'(rd_valid), 32'd0);
            end else begin
                applyStimulus(1'b0, 0, 1'b0, 0, 4'h0, 1'b0);
            end
        end
    endtask

    int dfltAddr [10] = '{0, 8, 1, 2, 3, 4, 5, 13, 6, 7};
    int dfltCode [10] = '{0, 1, 4, 5, 6, 7, 8, 9, 3, 2};

    task automatic readDefaults();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, dfltAddr[i], 1'b0, 0, 4'h0, 1'b0);
            checkOutput("dflt_ctrl", 32'(ctrl_out), 32'(dfltCode[i]));
            checkOutput("dflt_valid", 32'(rd_valid), 32'd1);
            checkOutput("dflt_illegal", 32'(illegal), 32'd0);
        end
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        restore = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_ctrl", 32'(ctrl_out), 32'hF);
        checkOutput("reset_cnt", 32'(ill_count), 32'd0);
        rst_n = 1'b1;
        measureBusy(1'b0, n);
        checkOutput("busy_len_reset", 32'(n), 32'd16);
        checkOutput("idle_ctrl", 32'(ctrl_out), 32'hF);
        checkOutput("idle_valid", 32'(rd_valid), 32'd0);

        readDefaults();

        applyStimulus(1'b1, 9, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("ill9_ctrl", 32'(ctrl_out), 32'hF);
        checkOutput("ill9_flag", 32'(illegal), 32'd1);
        checkOutput("ill9_cnt", 32'(ill_count), 32'd1);
        applyStimulus(1'b1, 15, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("ill15_flag", 32'(illegal), 32'd1);
        checkOutput("ill15_cnt", 32'(ill_count), 32'd2);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 9, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("ill_saturate", 32'(ill_count), 32'd255);

        applyStimulus(1'b1, 8, 1'b1, 8, 4'hA, 1'b0);
        checkOutput("wfirst_ctrl", 32'(ctrl_out), 32'hA);
        applyStimulus(1'b1, 8, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("reread8", 32'(ctrl_out), 32'hA);
        applyStimulus(1'b1, 3, 1'b1, 2, 4'hC, 1'b0);
        checkOutput("diff_addr_rd", 32'(ctrl_out), 32'd6);
        applyStimulus(1'b1, 2, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("diff_addr_wr", 32'(ctrl_out), 32'hC);
        applyStimulus(1'b0, 0, 1'b1, 1, 4'hF, 1'b0);
        applyStimulus(1'b1, 1, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("wr_illegal_flag", 32'(illegal), 32'd1);
        checkOutput("wr_illegal_cnt", 32'(ill_count), 32'd255);

        applyStimulus(1'b1, 8, 1'b1, 4, 4'h0, 1'b1);
        checkOutput("restore_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("restore_rd_ctrl", 32'(ctrl_out), 32'hA);
        checkOutput("restore_busy", 32'(busy), 32'd1);
        measureBusy(1'b1, n);
        checkOutput("busy_len_restore", 32'(n), 32'd16);
        applyStimulus(1'b1, 8, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("post_restore_8", 32'(ctrl_out), 32'd1);
        applyStimulus(1'b1, 1, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("post_restore_1", 32'(ctrl_out), 32'd4);
        applyStimulus(1'b1, 4, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("dropped_write_4", 32'(ctrl_out), 32'd7);
        applyStimulus(1'b1, 2, 1'b0, 0, 4'h0, 1'b0);
        checkOutput("post_restore_2", 32'(ctrl_out), 32'd5);
        checkOutput("restore_keeps_cnt", 32'(ill_count), 32'd255);

        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 4'h0, 1'b0);
        rst_n = 1'b1;
        repeat (7) applyStimulus(1'b0, 0, 1'b0, 0, 4'h0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 4'h0, 1'b0);
        rst_n = 1'b1;
        measureBusy(1'b0, n);
        checkOutput("busy_len_midreset", 32'(n), 32'd16);
        checkOutput("midreset_cnt", 32'(ill_count), 32'd0);
        readDefaults();
        checkOutput("final_cnt", 32'(ill_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
